// File: rtl/fpu_fma_wb_buffer.sv
// Writeback skid FIFO between the FMA result port and the register-file
// writeback stage. Holds {result, status, tag} entries in push order,
// accumulates sticky IEEE exception flags as entries retire, and supports
// a single-cycle flush that drops everything still buffered.
module fpu_fma_wb_buffer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 2,
    parameter int TAG_WIDTH = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         fma_result_i,
    input  logic [4:0]               fma_status_i,
    input  logic [TAG_WIDTH-1:0]     fma_tag_i,
    input  logic                     fma_valid_i,
    output logic                     fma_ready_o,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [WIDTH-1:0]         wb_result_o,
    output logic [4:0]               wb_status_o,
    output logic [TAG_WIDTH-1:0]     wb_tag_o,
    output logic [4:0]               fflags_o,
    input  logic                     fflags_clr_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0]     res_mem_q [DEPTH];
    logic [4:0]           sts_mem_q [DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       fflags_q, fflags_d;
    logic             rdy_en_q;
    logic             push, pop;

    // Ready is held low during reset and until the first edge after release;
    // otherwise it depends only on the registered occupancy.
    assign fma_ready_o = rdy_en_q && (count_q < CNT_W'(DEPTH));
    assign wb_valid_o  = (count_q != '0);
    assign busy_o      = wb_valid_o;
    assign count_o     = count_q;
    assign fflags_o    = fflags_q;

    assign push = fma_valid_i && fma_ready_o && !flush_i;
    assign pop  = wb_valid_o && wb_ready_i && !flush_i;

    // Head entry is presented only while valid so an empty buffer reads as zero.
    assign wb_result_o = wb_valid_o ? res_mem_q[rptr_q] : '0;
    assign wb_status_o = wb_valid_o ? sts_mem_q[rptr_q] : '0;
    assign wb_tag_o    = wb_valid_o ? tag_mem_q[rptr_q] : '0;

    // Next-state for pointers, occupancy and sticky flags.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        fflags_d = fflags_q;

        if (push) wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Flush drops the occupancy and pointers; the flags already
        // accumulated belong to retired instructions and are kept.
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end

        // A clear that coincides with a retire leaves exactly that retire's flags.
        if (pop)               fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | sts_mem_q[rptr_q];
        else if (fflags_clr_i) fflags_d = 5'b0;
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            fflags_q <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Entry storage; contents are don't-care until occupied, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            res_mem_q[wptr_q] <= fma_result_i;
            sts_mem_q[wptr_q] <= fma_status_i;
            tag_mem_q[wptr_q] <= fma_tag_i;
        end
    end

endmodule

// File: tb/tb_fpu_fma_wb_buffer.sv
// Directed bench for the FMA writeback buffer: reset, single op,
// backpressure, flag accumulation/clear, flush, async reset mid-op and
// streaming with pointer wrap.
module tb_fpu_fma_wb_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int TAGW  = 5;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic [WIDTH-1:0]  fma_result_i;
    logic [4:0]        fma_status_i;
    logic [TAGW-1:0]   fma_tag_i;
    logic              fma_valid_i;
    logic              fma_ready_o;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [WIDTH-1:0]  wb_result_o;
    logic [4:0]        wb_status_o;
    logic [TAGW-1:0]   wb_tag_o;
    logic [4:0]        fflags_o;
    logic              fflags_clr_i;
    logic [1:0]        count_o;
    logic              busy_o;

    int errors = 0;
    int checks = 0;

    fpu_fma_wb_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_WIDTH(TAGW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .fma_result_i (fma_result_i),
        .fma_status_i (fma_status_i),
        .fma_tag_i    (fma_tag_i),
        .fma_valid_i  (fma_valid_i),
        .fma_ready_o  (fma_ready_o),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_result_o  (wb_result_o),
        .wb_status_o  (wb_status_o),
        .wb_tag_o     (wb_tag_o),
        .fflags_o     (fflags_o),
        .fflags_clr_i (fflags_clr_i),
        .count_o      (count_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] st,
                         input logic [4:0] tag);
        fma_valid_i  = v;
        fma_result_i = res;
        fma_status_i = st;
        fma_tag_i    = tag;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
        drive(1'b0, 32'h0, 5'h0, 5'h0);
        tick(); tick();
        checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count_o); end
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %0b expected 0", wb_valid_o); end
        checks++; if (fma_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b expected 0", fma_ready_o); end
        checks++; if (fflags_o !== 5'd0) begin errors++; $display("FAIL rst_fflags: got %0h expected 0", fflags_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy_o); end
        checks++; if ({wb_result_o, wb_status_o, wb_tag_o} !== '0) begin errors++; $display("FAIL rst_wb_data: got %0h expected 0", {wb_result_o, wb_status_o, wb_tag_o}); end
        rst_ni = 1'b1;
        tick();
        checks++; if (fma_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b expected 1", fma_ready_o); end
    endtask

    task automatic test_single_op();
        wb_ready_i = 1'b1;
        drive(1'b1, 32'h4000_0000, 5'h0, 5'd3);
        tick();
        drive(1'b0, 32'h0, 5'h0, 5'h0);
        checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", wb_valid_o); end
        checks++; if (wb_result_o !== 32'h4000_0000) begin errors++; $display("FAIL single_result: got %0h expected 40000000", wb_result_o); end
        checks++; if (wb_tag_o !== 5'd3) begin errors++; $display("FAIL single_tag: got %0d expected 3", wb_tag_o); end
        checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count_o); end
        tick();
        checks++; if (wb_valid_o !== 1'b0 || count_o !== 2'd0) begin errors++; $display("FAIL single_empty: got valid=%0b count=%0d expected 0/0", wb_valid_o, count_o); end
        checks++; if (wb_result_o !== 32'h0) begin errors++; $display("FAIL single_empty_result: got %0h expected 0", wb_result_o); end
        checks++; if (fflags_o !== 5'd0) begin errors++; $display("FAIL single_fflags: got %0h expected 0", fflags_o); end
    endtask

    task automatic test_backpressure();
        wb_ready_i = 1'b0;
        drive(1'b1, 32'h11, 5'h0, 5'd1); tick();
        drive(1'b1, 32'h22, 5'h0, 5'd2); tick();
        checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL bp_count_full: got %0d expected 2", count_o); end
        checks++; if (fma_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %0b expected 0", fma_ready_o); end
        drive(1'b1, 32'h33, 5'h0, 5'd3); tick();
        checks++; if (count_o !== 2'd2 || wb_tag_o !== 5'd1) begin errors++; $display("FAIL bp_hold: got count=%0d tag=%0d expected 2/1", count_o, wb_tag_o); end
        checks++; if (wb_result_o !== 32'h11) begin errors++; $display("FAIL bp_hold_result: got %0h expected 11", wb_result_o); end
        wb_ready_i = 1'b1;
        tick();
        checks++; if (wb_tag_o !== 5'd2 || count_o !== 2'd1) begin errors++; $display("FAIL bp_pop1: got tag=%0d count=%0d expected 2/1", wb_tag_o, count_o); end
        checks++; if (fma_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %0b expected 1", fma_ready_o); end
        tick();
        drive(1'b0, 32'h0, 5'h0, 5'h0);
        checks++; if (wb_tag_o !== 5'd3 || count_o !== 2'd1) begin errors++; $display("FAIL bp_pop2: got tag=%0d count=%0d expected 3/1", wb_tag_o, count_o); end
        tick();
        checks++; if (wb_valid_o !== 1'b0 || count_o !== 2'd0) begin errors++; $display("FAIL bp_drain: got valid=%0b count=%0d expected 0/0", wb_valid_o, count_o); end
    endtask

    task automatic test_flags();
        wb_ready_i = 1'b0;
        drive(1'b1, 32'h1, 5'b00001, 5'd4); tick();
        drive(1'b1, 32'h2, 5'b10000, 5'd5); tick();
        drive(1'b0, 32'h0, 5'h0, 5'h0);
        checks++; if (fflags_o !== 5'b00000) begin errors++; $display("FAIL flags_no_pop: got %b expected 00000", fflags_o); end
        wb_ready_i = 1'b1;
        tick();
        checks++; if (fflags_o !== 5'b00001) begin errors++; $display("FAIL flags_pop1: got %b expected 00001", fflags_o); end
        tick();
        checks++; if (fflags_o !== 5'b10001) begin errors++; $display("FAIL flags_pop2: got %b expected 10001", fflags_o); end
        wb_ready_i = 1'b0;
        drive(1'b1, 32'h3, 5'b00100, 5'd6); tick();
        drive(1'b0, 32'h0, 5'h0, 5'h0);
        wb_ready_i = 1'b1; fflags_clr_i = 1'b1;
        tick();
        fflags_clr_i = 1'b0;
        checks++; if (fflags_o !== 5'b00100) begin errors++; $display("FAIL flags_clr_pop: got %b expected 00100", fflags_o); end
    endtask

    task automatic test_flush();
        wb_ready_i = 1'b0;
        drive(1'b1, 32'hA, 5'b01000, 5'd8); tick();
        drive(1'b1, 32'hB, 5'b01000, 5'd9); tick();
        checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d expected 2", count_o); end
        flush_i = 1'b1; wb_ready_i = 1'b1;
        drive(1'b1, 32'hC, 5'b00010, 5'd7);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 5'h0, 5'h0);
        checks++; if (count_o !== 2'd0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty: got count=%0d valid=%0b expected 0/0", count_o, wb_valid_o); end
        checks++; if (fflags_o !== 5'b00100) begin errors++; $display("FAIL flush_fflags: got %b expected 00100", fflags_o); end
        tick();
        checks++; if (count_o !== 2'd0 || busy_o !== 1'b0 || fflags_o !== 5'b00100) begin errors++; $display("FAIL flush_empty_pop: got count=%0d busy=%0b fflags=%b expected 0/0/00100", count_o, busy_o, fflags_o); end
        fflags_clr_i = 1'b1;
        tick();
        fflags_clr_i = 1'b0;
        checks++; if (fflags_o !== 5'b00000) begin errors++; $display("FAIL flags_clr_only: got %b expected 00000", fflags_o); end
    endtask

    task automatic test_reset_midop();
        wb_ready_i = 1'b0;
        drive(1'b1, 32'h55, 5'b00001, 5'd12); tick();
        drive(1'b0, 32'h0, 5'h0, 5'h0);
        checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %0b expected 1", wb_valid_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (wb_valid_o !== 1'b0 || count_o !== 2'd0) begin errors++; $display("FAIL midrst_async: got valid=%0b count=%0d expected 0/0", wb_valid_o, count_o); end
        checks++; if (fma_ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %0b expected 0", fma_ready_o); end
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        wb_ready_i = 1'b1;
        tick();
        checks++; if (fma_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %0b expected 1", fma_ready_o); end
        checks++; if (wb_valid_o !== 1'b0 || fflags_o !== 5'd0) begin errors++; $display("FAIL midrst_no_emerge: got valid=%0b fflags=%b expected 0/00000", wb_valid_o, fflags_o); end
    endtask

    task automatic test_streaming();
        wb_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100 + i, 5'h0, 5'(i));
            tick();
            checks++;
            if (count_o !== 2'd1 || wb_tag_o !== 5'(i) || wb_result_o !== 32'h100 + i) begin
                errors++;
                $display("FAIL stream_%0d: got count=%0d tag=%0d result=%0h expected 1/%0d/%0h",
                         i, count_o, wb_tag_o, wb_result_o, i, 32'h100 + i);
            end
        end
        drive(1'b0, 32'h0, 5'h0, 5'h0);
        tick();
        checks++; if (count_o !== 2'd0 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain: got count=%0d valid=%0b expected 0/0", count_o, wb_valid_o); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_flags();
        test_flush();
        test_reset_midop();
        test_streaming();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
